// File: rtl/gemm_rr_scheduler.sv
// ---------------------------------------------------------------------------
// gemm_rr_scheduler
//
// Time-shares one chunked GEMM engine among NumReq requesters. Each job pushes
// one full input vector of the owning requester through the engine. The owner
// is picked round-robin. The engine's chunk-pointer requests are routed back
// to that owner only. Output elements go to the owner with a one-hot tag.
//
// Ports:
//   clk_in, rst_in          clock, asynchronous active-high reset
//   req_valid               per-requester "complete vector available"
//   req_chunk_data          flat {req N-1 .. req 0} current input chunks
//   req_chunk_adv/_rst      per-requester read-pointer advance / rewind
//   res_data/res_valid      output element plus one-hot owner tag
//   res_done                one-cycle job-complete pulse to the owner
//   grant                   one-hot current owner (0 when idle)
//   err                     sticky watchdog error (0 without the watchdog)
//   eng_*                   start strobe, chunk data and strobes of the engine
//
// Build option: define GEMM_RR_SCHED_WATCHDOG_EN to compile in a stall
// watchdog that aborts a job after TimeoutCycles strobe-free RUN cycles.
// ---------------------------------------------------------------------------
module gemm_rr_scheduler #(
    parameter int NumReq        = 4,
    parameter int WorkingRegs   = 4,
    parameter int NBits         = 8,
    parameter int OutVecLength  = 8,
    parameter int TimeoutCycles = 256
) (
    input  logic                                 clk_in,
    input  logic                                 rst_in,
    input  logic [NumReq-1:0]                    req_valid,
    input  logic [NumReq*WorkingRegs*NBits-1:0]  req_chunk_data,
    output logic [NumReq-1:0]                    req_chunk_adv,
    output logic [NumReq-1:0]                    req_chunk_rst,
    output logic [NBits-1:0]                     res_data,
    output logic [NumReq-1:0]                    res_valid,
    output logic [NumReq-1:0]                    res_done,
    output logic [NumReq-1:0]                    grant,
    output logic                                 err,
    output logic                                 eng_in_data_ready,
    output logic [WorkingRegs*NBits-1:0]         eng_in_data,
    input  logic                                 eng_req_chunk_in,
    input  logic                                 eng_req_chunk_ptr_rst,
    input  logic                                 eng_req_chunk_out,
    input  logic [NBits-1:0]                     eng_write_out_data,
    input  logic                                 eng_out_vector_valid
);

    localparam int IdxW   = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int ChunkW = WorkingRegs * NBits;
    localparam int CntW   = $clog2(OutVecLength + 1);

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_e;

    state_e             state_q, state_d;
    logic [NumReq-1:0]  grant_q, grant_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]    elem_cnt_q, elem_cnt_d;

    logic               pick_found;
    logic [IdxW-1:0]    pick_idx;
    logic [IdxW-1:0]    cand_idx;
    logic               in_run;
    logic               job_end;
    logic               timeout;

    assign in_run  = (state_q == RUN);
    // A job ends on the engine's last-element flag or on a watchdog abort.
    assign job_end = in_run && (eng_out_vector_valid || timeout);

    // Circular search for the first valid requester at or after rr_ptr.
    always_comb begin
        // NOTE: every variable written here gets a default first so no latch is inferred.
        pick_found = 1'b0;
        pick_idx   = '0;
        cand_idx   = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand_idx = IdxW'((int'(rr_ptr_q) + i) % NumReq);
            if (!pick_found && req_valid[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

`ifdef GEMM_RR_SCHED_WATCHDOG_EN
    localparam int WdW = $clog2(TimeoutCycles + 1);

    logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
    logic           err_q, err_d;
    logic           any_strobe;

    assign any_strobe = eng_req_chunk_in | eng_req_chunk_ptr_rst |
                        eng_req_chunk_out | eng_out_vector_valid;
    // Fires in the stall cycle that brings the count to TimeoutCycles, so the
    // abort pulse and err coincide with that cycle.
    assign timeout = in_run && !any_strobe && (wd_cnt_q == WdW'(TimeoutCycles - 1));

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        err_d    = err_q | timeout;
        if (state_q == START) begin
            wd_cnt_d = '0;
        end else if (in_run) begin
            wd_cnt_d = any_strobe ? '0 : wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wd_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wd_cnt_q <= wd_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err = err_q | timeout;
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (pick_found) state_d = START;
            START:   state_d = RUN;
            RUN:     if (job_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Owner, round-robin pointer and element counter.
    always_comb begin
        grant_d    = grant_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        elem_cnt_d = elem_cnt_q;
        if (state_q == IDLE && pick_found) begin
            grant_d = NumReq'(1) << pick_idx;
            owner_d = pick_idx;
        end
        if (state_q == START) begin
            elem_cnt_d = '0;
        end
        if (in_run && eng_req_chunk_out) begin
            elem_cnt_d = elem_cnt_q + 1'b1;
        end
        // Grant drops on leaving RUN so it already reads 0 during DONE.
        if (job_end) begin
            grant_d  = '0;
            rr_ptr_d = IdxW'((int'(owner_q) + 1) % NumReq);
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            grant_q    <= '0;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            elem_cnt_q <= '0;
        end else begin
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            elem_cnt_q <= elem_cnt_d;
        end
    end

    // Outputs: a zero-latency mux between the owner and the engine, with
    // every forwarded strobe masked outside RUN.
    always_comb begin
        grant             = grant_q;
        eng_in_data_ready = (state_q == START);
        eng_in_data       = '0;
        req_chunk_adv     = '0;
        req_chunk_rst     = '0;
        res_valid         = '0;
        res_data          = '0;
        res_done          = '0;
        if (state_q == START || in_run) begin
            eng_in_data = req_chunk_data[int'(owner_q)*ChunkW +: ChunkW];
        end
        if (in_run) begin
            req_chunk_adv = grant_q & {NumReq{eng_req_chunk_in}};
            req_chunk_rst = grant_q & {NumReq{eng_req_chunk_ptr_rst}};
            res_valid     = grant_q & {NumReq{eng_req_chunk_out}};
            res_data      = eng_write_out_data;
            if (job_end) begin
                res_done = grant_q;
            end
        end
    end

endmodule
